// File: rtl/disp_hole_fill.sv
// disp_hole_fill: fills short runs of invalid (0) disparities with the last
// valid disparity on the same row. The fill never crosses a row boundary, and
// a hole run is only filled for its first MAX_HOLE pixels.
// The design is a free-running two-stage pipeline with a fixed latency of 2
// clocks.
// Optional feature, enabled by defining HOLE_FILL_STATS_EN: saturating
// fill/drop hole counters (o_fill_cnt, o_drop_cnt).
module disp_hole_fill #(
  parameter int D        = 64,
  parameter int W        = 640,
  parameter int MAX_HOLE = 8,
  localparam int NBIT    = $clog2(D)
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_clr,
  input  logic            i_dval,
  input  logic [NBIT-1:0] i_data,
  output logic            o_dval,
  output logic [NBIT-1:0] o_data,
`ifdef HOLE_FILL_STATS_EN
  output logic            o_eol,
  output logic [31:0]     o_fill_cnt,
  output logic [31:0]     o_drop_cnt
`else
  output logic            o_eol
`endif
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = $clog2(MAX_HOLE + 2);
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] RUN_SAT  = RW'(MAX_HOLE + 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_HOLE);

  // stage 1 state
  logic [CW-1:0]   col;
  logic            s1_vld;
  logic [NBIT-1:0] s1_data;
  logic            s1_hole;
  logic            s1_sol;
  logic            s1_eol;

  // stage 2 fill state
  logic [NBIT-1:0] last_valid;
  logic [RW-1:0]   run;

  // stage 2 combinational results
  logic [NBIT-1:0] lv;
  logic [RW-1:0]   rn;
  logic [RW-1:0]   run_next;
  logic            fill;
  logic [NBIT-1:0] data_next;

  // Stage-2 decision: a row start discards the fill history, and the run
  // counter saturates so that long holes can never wrap back into fill range.
  always_comb begin
    lv        = last_valid;
    rn        = run;
    run_next  = run;
    fill      = 1'b0;
    data_next = s1_data;
    if (s1_sol) begin
      lv = '0;
      rn = '0;
    end else begin
      lv = last_valid;
      rn = run;
    end
    if (rn >= RUN_SAT) begin
      run_next = RUN_SAT;
    end else begin
      run_next = rn + RW'(1);
    end
    fill = (lv != '0) && (run_next <= RUN_MAX);
    if (!s1_hole) begin
      data_next = s1_data;
    end else if (fill) begin
      data_next = lv;
    end else begin
      data_next = '0;
    end
  end

  // Stage 1: capture the beat, classify it, and track the column position.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      col     <= '0;
      s1_vld  <= 1'b0;
      s1_data <= '0;
      s1_hole <= 1'b0;
      s1_sol  <= 1'b0;
      s1_eol  <= 1'b0;
    end else if (i_clr) begin
      col     <= '0;
      s1_vld  <= 1'b0;
      s1_data <= '0;
      s1_hole <= 1'b0;
      s1_sol  <= 1'b0;
      s1_eol  <= 1'b0;
    end else begin
      s1_vld <= i_dval;
      if (i_dval) begin
        s1_data <= i_data;
        s1_hole <= (i_data == '0);
        s1_sol  <= (col == '0);
        s1_eol  <= (col == COL_LAST);
        col     <= (col == COL_LAST) ? '0 : col + CW'(1);
      end
    end
  end

  // Stage 2: register filled output and update fill history; hold data/eol when idle.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_dval     <= 1'b0;
      o_data     <= '0;
      o_eol      <= 1'b0;
      last_valid <= '0;
      run        <= '0;
    end else if (i_clr) begin
      o_dval     <= 1'b0;
      o_data     <= '0;
      o_eol      <= 1'b0;
      last_valid <= '0;
      run        <= '0;
    end else begin
      o_dval <= s1_vld;
      if (s1_vld) begin
        o_data <= data_next;
        o_eol  <= s1_eol;
        if (s1_hole) begin
          last_valid <= lv;
          run        <= run_next;
        end else begin
          last_valid <= s1_data;
          run        <= '0;
        end
      end
    end
  end

`ifdef HOLE_FILL_STATS_EN
  // Saturating counters of filled holes and of holes passed through as 0.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_fill_cnt <= 32'd0;
      o_drop_cnt <= 32'd0;
    end else if (i_clr) begin
      o_fill_cnt <= 32'd0;
      o_drop_cnt <= 32'd0;
    end else if (s1_vld && s1_hole) begin
      if (fill) begin
        if (o_fill_cnt != 32'hFFFF_FFFF) begin
          o_fill_cnt <= o_fill_cnt + 32'd1;
        end
      end else begin
        if (o_drop_cnt != 32'hFFFF_FFFF) begin
          o_drop_cnt <= o_drop_cnt + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_disp_hole_fill.sv
// Scoreboard bench for disp_hole_fill (W=8, MAX_HOLE=2). The driver pushes
// expected beats computed from a row-history reference model; a negedge
// monitor pops and compares data, eol and latency.
module tb_disp_hole_fill;
  localparam int D    = 64;
  localparam int W    = 8;
  localparam int MH   = 2;
  localparam int NBIT = 6;

  logic            clk  = 1'b0;
  logic            rstn = 1'b0;
  logic            clr  = 1'b0;
  logic            dval = 1'b0;
  logic [NBIT-1:0] din  = '0;
  logic            odval;
  logic [NBIT-1:0] odata;
  logic            oeol;
`ifdef HOLE_FILL_STATS_EN
  logic [31:0]     fill_cnt;
  logic [31:0]     drop_cnt;
`endif

  always #5 clk = ~clk;

  disp_hole_fill #(.D(D), .W(W), .MAX_HOLE(MH)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .i_clr  (clr),
    .i_dval (dval),
    .i_data (din),
    .o_dval (odval),
    .o_data (odata),
`ifdef HOLE_FILL_STATS_EN
    .o_eol      (oeol),
    .o_fill_cnt (fill_cnt),
    .o_drop_cnt (drop_cnt)
`else
    .o_eol  (oeol)
`endif
  );

  typedef struct {
    int data;
    int eol;
    int cyc;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int row_px[W];
  int mcol = 0;
  int m_fill = 0;
  int m_drop = 0;
  int hold_data = 0;
  int hold_eol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a hole takes the nearest earlier nonzero pixel of the same row,
  // provided that the hole is at most MH pixels into its run of zeros.
  function automatic void model_beat(input int d);
    exp_t e;
    int k;
    int c;
    row_px[mcol] = d;
    if (d != 0) begin
      e.data = d;
    end else begin
      k = 0;
      c = mcol;
      while (c >= 0 && row_px[c] == 0) begin
        k++;
        c--;
      end
      if (c >= 0 && k <= MH) begin
        e.data = row_px[c];
        m_fill++;
      end else begin
        e.data = 0;
        m_drop++;
      end
    end
    e.eol = (mcol == W - 1) ? 1 : 0;
    e.cyc = cyc;
    q.push_back(e);
    mcol = (mcol + 1) % W;
  endfunction

  function automatic void flush();
    q.delete();
    mcol = 0;
    m_fill = 0;
    m_drop = 0;
    hold_data = 0;
    hold_eol = 0;
  endfunction

  // monitor: compare every presented beat, and check that idle outputs hold
  always @(negedge clk) begin
    exp_t e;
    if (odval) begin
      if (q.size() == 0) begin
        check("spurious_dval", int'(odval), 0);
      end else begin
        e = q.pop_front();
        check("data", int'(odata), e.data);
        check("eol", int'(oeol), e.eol);
        check("latency", cyc - e.cyc, 2);
        hold_data = e.data;
        hold_eol = e.eol;
      end
    end else begin
      check("hold_data", int'(odata), hold_data);
      check("hold_eol", int'(oeol), hold_eol);
    end
  end

  task automatic beat(input logic v, input int d);
    dval = v;
    din = NBIT'(d);
    if (v) model_beat(d);
    @(posedge clk);
    #1;
    dval = 1'b0;
  endtask

  task automatic row(input int a0, input int a1, input int a2, input int a3,
                     input int a4, input int a5, input int a6, input int a7);
    beat(1'b1, a0); beat(1'b1, a1); beat(1'b1, a2); beat(1'b1, a3);
    beat(1'b1, a4); beat(1'b1, a5); beat(1'b1, a6); beat(1'b1, a7);
  endtask

  task automatic do_clr(input logic v, input int d);
    clr = 1'b1;
    dval = v;
    din = NBIT'(d);
    @(posedge clk);
    #1;
    clr = 1'b0;
    dval = 1'b0;
    flush();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_queue_empty", q.size(), 0);
  endtask

  task automatic check_stats(input string tag);
`ifdef HOLE_FILL_STATS_EN
    check({tag, "_fill_cnt"}, int'(fill_cnt), m_fill);
    check({tag, "_drop_cnt"}, int'(drop_cnt), m_drop);
`else
    tests = tests + 0;
`endif
  endtask

  initial begin
    for (int i = 0; i < W; i++) row_px[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dval", int'(odval), 0);
    check("rst_data", int'(odata), 0);
    check("rst_eol", int'(oeol), 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // basic fill, MAX_HOLE cutoff, eol on the 8th beat
    row(5, 0, 0, 7, 0, 0, 0, 3);
    drain();
    check_stats("row1");
    do_clr(1'b0, 0);
    check_stats("after_clr");

    // no fill across a row boundary
    row(1, 2, 3, 4, 5, 6, 4, 0);
    row(0, 6, 1, 1, 1, 1, 1, 1);
    drain();

    // gapped beats: column advances only on valid beats
    beat(1'b1, 9); beat(1'b0, 33); beat(1'b1, 0); beat(1'b0, 44);
    drain();

    // clear mid-row after three beats; the beat presented with clear is discarded
    beat(1'b1, 12); beat(1'b1, 0); beat(1'b1, 13);
    do_clr(1'b1, 17);
    row(0, 8, 0, 0, 0, 0, 2, 0);
    drain();

    // long holes: saturation must not wrap back into fill range
    row(5, 0, 0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0);
    drain();
    check_stats("directed");

    // asynchronous reset mid-row: next beat is column 0 again
    beat(1'b1, 21); beat(1'b1, 0); beat(1'b1, 22);
    rstn = 1'b0;
    flush();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midrst_dval", int'(odval), 0);
    check("midrst_data", int'(odata), 0);
    rstn = 1'b1;
    row(3, 0, 0, 0, 4, 0, 1, 0);
    drain();

    // randomized traffic with idle gaps and occasional clears
    for (int i = 0; i < 3000; i++) begin
      int r;
      int d;
      r = $urandom_range(0, 199);
      d = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, D - 1);
      if (r == 0) begin
        do_clr(1'($urandom_range(0, 1)), d);
      end else begin
        beat(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, d);
      end
    end
    drain();
    check_stats("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
